// File: rtl/defender_pkg.sv
// Shared screen geometry and coordinate type for the player, collision and render blocks.
package defender_pkg;

    localparam int unsigned W        = 10;
    localparam int unsigned X_INIT   = 320;
    localparam int unsigned Y_PLAYER = 420;
    localparam int unsigned X_MIN    = 90;
    localparam int unsigned X_MAX    = 550;
    localparam int unsigned PARK_Y   = 470;

    typedef logic [W-1:0] coord_t;

    typedef enum logic [1:0] {
        MOVE_HOLD  = 2'd0,
        MOVE_LEFT  = 2'd1,
        MOVE_RIGHT = 2'd2
    } move_t;

endpackage

// File: rtl/proj_slot.sv
// One projectile slot: spawns at the player, climbs each tick, parks on hit or top of screen.
module proj_slot #(
    parameter int unsigned W         = defender_pkg::W,
    parameter int unsigned Y_SPAWN   = defender_pkg::Y_PLAYER,
    parameter int unsigned PROJ_STEP = 2,
    parameter int unsigned PARK_Y    = defender_pkg::PARK_Y
) (
    input  logic         dclk,
    input  logic         clr_n,
    input  logic         play,
    input  logic         tick,
    input  logic         spawn,
    input  logic [W-1:0] spawn_x,
    input  logic         collide,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         active
);

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            x      <= '0;
            y      <= W'(PARK_Y);
            active <= 1'b0;
        end else if (!play || (collide && active)) begin
            // A hit parks the slot on any edge; spawn only ever targets inactive slots.
            x      <= '0;
            y      <= W'(PARK_Y);
            active <= 1'b0;
        end else if (tick && spawn) begin
            x      <= spawn_x;
            y      <= W'(Y_SPAWN);
            active <= 1'b1;
        end else if (tick && active) begin
            if (y >= W'(PROJ_STEP)) begin
                y <= y - W'(PROJ_STEP);
            end else begin
                x      <= '0;
                y      <= W'(PARK_Y);
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/player_multi.sv
// Player ship movement, fire cooldown and lowest-free-slot allocation over a pool of projectiles.
module player_multi #(
    parameter int unsigned N_PROJ      = 4,
    parameter int unsigned W           = defender_pkg::W,
    parameter int unsigned X_INIT      = defender_pkg::X_INIT,
    parameter int unsigned Y_PLAYER    = defender_pkg::Y_PLAYER,
    parameter int unsigned X_MIN       = defender_pkg::X_MIN,
    parameter int unsigned X_MAX       = defender_pkg::X_MAX,
    parameter int unsigned PLAYER_STEP = 1,
    parameter int unsigned PROJ_STEP   = 2,
    parameter int unsigned PARK_Y      = defender_pkg::PARK_Y,
    parameter int unsigned COOLDOWN    = 8
) (
    input  logic                dclk,
    input  logic                clr_n,
    input  logic                tick,
    input  logic                play,
    input  logic                left,
    input  logic                right,
    input  logic                shoot,
    input  logic [N_PROJ-1:0]   collide,
    output logic [W-1:0]        player_x,
    output logic [W-1:0]        player_y,
    output logic [N_PROJ*W-1:0] proj_x,
    output logic [N_PROJ*W-1:0] proj_y,
    output logic [N_PROJ-1:0]   proj_active,
    output logic                fire_ack
);

    import defender_pkg::*;

    logic [W-1:0]      cooldown;
    logic [W-1:0]      x_next;
    logic [W:0]        x_dec;
    logic [W:0]        x_inc;
    move_t             move;
    logic [N_PROJ-1:0] sel;
    logic [N_PROJ-1:0] spawn;
    logic              found;
    logic              fire;

    assign player_y = W'(Y_PLAYER);

    assign x_dec = {1'b0, player_x} - (W+1)'(PLAYER_STEP);
    assign x_inc = {1'b0, player_x} + (W+1)'(PLAYER_STEP);

    always_comb begin
        move = MOVE_HOLD;
        if (left && !right) begin
            move = MOVE_LEFT;
        end else if (right && !left) begin
            move = MOVE_RIGHT;
        end
    end

    // The extra bit of x_dec catches a borrow so small x never wraps past X_MIN.
    always_comb begin
        x_next = player_x;
        case (move)
            MOVE_LEFT:  x_next = (x_dec[W] || (x_dec < (W+1)'(X_MIN))) ? W'(X_MIN) : x_dec[W-1:0];
            MOVE_RIGHT: x_next = (x_inc > (W+1)'(X_MAX)) ? W'(X_MAX) : x_inc[W-1:0];
            default:    x_next = player_x;
        endcase
    end

    // Allocation looks only at the pre-edge active mask, so a slot freed by a hit waits a tick.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_PROJ; i++) begin
            if (!proj_active[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign fire  = play && tick && shoot && (cooldown == '0) && found;
    assign spawn = fire ? sel : '0;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            player_x <= W'(X_INIT);
            cooldown <= '0;
            fire_ack <= 1'b0;
        end else if (!play) begin
            player_x <= W'(X_INIT);
            cooldown <= '0;
            fire_ack <= 1'b0;
        end else begin
            fire_ack <= fire;
            if (tick) begin
                player_x <= x_next;
                if (fire) begin
                    cooldown <= W'(COOLDOWN);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < N_PROJ; i++) begin : g_slot
        proj_slot #(
            .W         (W),
            .Y_SPAWN   (Y_PLAYER),
            .PROJ_STEP (PROJ_STEP),
            .PARK_Y    (PARK_Y)
        ) u_slot (
            .dclk    (dclk),
            .clr_n   (clr_n),
            .play    (play),
            .tick    (tick),
            .spawn   (spawn[i]),
            .spawn_x (player_x),
            .collide (collide[i]),
            .x       (proj_x[i*W +: W]),
            .y       (proj_y[i*W +: W]),
            .active  (proj_active[i])
        );
    end

endmodule

// File: tb/tb_player_multi.sv
// Directed bench for player_multi: movement bounds, shot allocation, hits, floor parking, reset.
module tb_player_multi;

    localparam int N = 4;
    localparam int W = 10;

    logic         dclk = 1'b0;
    logic         clr_n, tick, play, left, right, shoot;
    logic [N-1:0] collide;

    logic [W-1:0]   player_x, player_y;
    logic [N*W-1:0] proj_x, proj_y;
    logic [N-1:0]   proj_active;
    logic           fire_ack;

    logic [W-1:0]   player_x3, player_y3;
    logic [N*W-1:0] proj_x3, proj_y3;
    logic [N-1:0]   proj_active3;
    logic           fire_ack3;

    int checks   = 0;
    int failures = 0;

    player_multi dut (
        .dclk(dclk), .clr_n(clr_n), .tick(tick), .play(play), .left(left), .right(right),
        .shoot(shoot), .collide(collide), .player_x(player_x), .player_y(player_y),
        .proj_x(proj_x), .proj_y(proj_y), .proj_active(proj_active), .fire_ack(fire_ack)
    );

    // Step of 3 from a spawn height of 421 lands exactly on y=1.
    player_multi #(.PROJ_STEP(3), .Y_PLAYER(421)) dut3 (
        .dclk(dclk), .clr_n(clr_n), .tick(tick), .play(play), .left(left), .right(right),
        .shoot(shoot), .collide(collide), .player_x(player_x3), .player_y(player_y3),
        .proj_x(proj_x3), .proj_y(proj_y3), .proj_active(proj_active3), .fire_ack(fire_ack3)
    );

    always #5 dclk = ~dclk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [W-1:0] field(input logic [N*W-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic step();
        @(negedge dclk);
        tick = 1'b1;
        @(negedge dclk);
        tick = 1'b0;
    endtask

    task automatic reinit();
        @(negedge dclk);
        play = 1'b0;
        @(negedge dclk);
        play = 1'b1;
    endtask

    task automatic test_reset();
        int acks;
        clr_n = 1'b0; play = 1'b0; tick = 1'b0; left = 1'b0; right = 1'b0;
        shoot = 1'b0; collide = '0;
        #12;
        checks++; if (player_x !== 10'd320) begin failures++; $display("FAIL reset_player_x got=%0d exp=320", player_x); end
        checks++; if (player_y !== 10'd420) begin failures++; $display("FAIL reset_player_y got=%0d exp=420", player_y); end
        checks++; if (proj_y !== {N{10'd470}}) begin failures++; $display("FAIL reset_proj_y got=%h", proj_y); end
        checks++; if (proj_x !== '0) begin failures++; $display("FAIL reset_proj_x got=%h exp=0", proj_x); end
        checks++; if (proj_active !== 4'b0000) begin failures++; $display("FAIL reset_active got=%b exp=0000", proj_active); end
        checks++; if (fire_ack !== 1'b0) begin failures++; $display("FAIL reset_fire_ack got=%b exp=0", fire_ack); end
        @(negedge dclk);
        clr_n = 1'b1; play = 1'b1;
        acks = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (fire_ack !== 1'b0) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL idle_fire_ack got=%0d pulses exp=0", acks); end
        checks++; if (player_x !== 10'd320) begin failures++; $display("FAIL idle_player_x got=%0d exp=320", player_x); end
        checks++; if (proj_active !== 4'b0000) begin failures++; $display("FAIL idle_active got=%b exp=0000", proj_active); end
        checks++; if (proj_y !== {N{10'd470}}) begin failures++; $display("FAIL idle_proj_y got=%h", proj_y); end
    endtask

    task automatic test_move();
        int first_hit;
        first_hit = -1;
        right = 1'b1;
        for (int t = 1; t <= 300; t++) begin
            step();
            if (player_x === 10'd550 && first_hit < 0) first_hit = t;
        end
        checks++; if (first_hit != 230) begin failures++; $display("FAIL right_reach_tick got=%0d exp=230", first_hit); end
        checks++; if (player_x !== 10'd550) begin failures++; $display("FAIL right_clamp got=%0d exp=550", player_x); end
        left = 1'b1;
        for (int t = 0; t < 5; t++) step();
        checks++; if (player_x !== 10'd550) begin failures++; $display("FAIL both_hold got=%0d exp=550", player_x); end
        right = 1'b0;
        for (int t = 0; t < 470; t++) step();
        checks++; if (player_x !== 10'd90) begin failures++; $display("FAIL left_clamp got=%0d exp=90", player_x); end
        left = 1'b0;
        reinit();
        checks++; if (player_x !== 10'd320) begin failures++; $display("FAIL play_reinit_x got=%0d exp=320", player_x); end
    endtask

    task automatic test_fire();
        logic exp_ack;
        logic [W-1:0] exp_y;
        int k;
        shoot = 1'b1;
        for (int t = 0; t <= 40; t++) begin
            step();
            exp_ack = (t == 0 || t == 9 || t == 18 || t == 27);
            exp_y = 10'(420 - 2 * t);
            checks++; if (fire_ack !== exp_ack) begin failures++; $display("FAIL fire_ack_t%0d got=%b exp=%b", t, fire_ack, exp_ack); end
            checks++; if (field(proj_y, 0) !== exp_y) begin failures++; $display("FAIL slot0_y_t%0d got=%0d exp=%0d", t, field(proj_y, 0), exp_y); end
            if (exp_ack) begin
                k = t / 9;
                checks++; if (proj_active !== 4'((1 << (k + 1)) - 1)) begin failures++; $display("FAIL alloc_mask_t%0d got=%b", t, proj_active); end
                checks++; if (field(proj_y, k) !== 10'd420 || field(proj_x, k) !== 10'd320) begin
                    failures++; $display("FAIL alloc_slot%0d got=(%0d,%0d) exp=(320,420)", k, field(proj_x, k), field(proj_y, k)); end
            end
        end
        checks++; if (proj_active !== 4'b1111) begin failures++; $display("FAIL pool_full got=%b exp=1111", proj_active); end
    endtask

    task automatic test_collide();
        shoot = 1'b0;
        @(negedge dclk);
        collide = 4'b0001;
        @(negedge dclk);
        collide = '0;
        checks++; if (proj_active !== 4'b1110) begin failures++; $display("FAIL hit_active got=%b exp=1110", proj_active); end
        checks++; if (field(proj_x, 0) !== 10'd0 || field(proj_y, 0) !== 10'd470) begin
            failures++; $display("FAIL hit_park got=(%0d,%0d) exp=(0,470)", field(proj_x, 0), field(proj_y, 0)); end
        checks++; if (field(proj_y, 1) !== 10'd358) begin failures++; $display("FAIL hit_slot1_hold got=%0d exp=358", field(proj_y, 1)); end
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        checks++; if (fire_ack !== 1'b1) begin failures++; $display("FAIL realloc_ack got=%b exp=1", fire_ack); end
        checks++; if (proj_active !== 4'b1111 || field(proj_y, 0) !== 10'd420) begin
            failures++; $display("FAIL realloc_slot0 got=%b y=%0d exp=1111 y=420", proj_active, field(proj_y, 0)); end
        checks++; if (field(proj_y, 1) !== 10'd356) begin failures++; $display("FAIL realloc_slot1_y got=%0d exp=356", field(proj_y, 1)); end
        @(negedge dclk);
        collide = 4'b0100; tick = 1'b1;
        @(negedge dclk);
        collide = '0; tick = 1'b0;
        checks++; if (proj_active !== 4'b1011 || field(proj_y, 2) !== 10'd470) begin
            failures++; $display("FAIL hit_on_tick got=%b y=%0d exp=1011 y=470", proj_active, field(proj_y, 2)); end
    endtask

    task automatic test_no_wrap();
        reinit();
        shoot = 1'b1;
        step();
        shoot = 1'b0;
        checks++; if (proj_active3[0] !== 1'b1 || field(proj_y3, 0) !== 10'd421) begin
            failures++; $display("FAIL step3_spawn got=%b y=%0d exp=1 y=421", proj_active3[0], field(proj_y3, 0)); end
        for (int t = 0; t < 140; t++) step();
        checks++; if (proj_active3[0] !== 1'b1 || field(proj_y3, 0) !== 10'd1) begin
            failures++; $display("FAIL step3_at_1 got=%b y=%0d exp=1 y=1", proj_active3[0], field(proj_y3, 0)); end
        step();
        checks++; if (proj_active3[0] !== 1'b0 || field(proj_y3, 0) !== 10'd470 || field(proj_x3, 0) !== 10'd0) begin
            failures++; $display("FAIL step3_park got=%b (%0d,%0d) exp=0 (0,470)", proj_active3[0], field(proj_x3, 0), field(proj_y3, 0)); end
    endtask

    task automatic test_async_reset();
        int acks;
        reinit();
        shoot = 1'b1; right = 1'b1;
        for (int t = 0; t < 19; t++) step();
        checks++; if (proj_active !== 4'b0111 || player_x !== 10'd339 || fire_ack !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=%b x=%0d ack=%b exp=0111 x=339 ack=1", proj_active, player_x, fire_ack); end
        #2 clr_n = 1'b0;
        #1;
        checks++; if (proj_active !== 4'b0000 || proj_y !== {N{10'd470}} || proj_x !== '0) begin
            failures++; $display("FAIL async_slots got=%b y=%h x=%h", proj_active, proj_y, proj_x); end
        checks++; if (player_x !== 10'd320 || fire_ack !== 1'b0) begin
            failures++; $display("FAIL async_player got=%0d ack=%b exp=320 ack=0", player_x, fire_ack); end
        play = 1'b0;
        @(negedge dclk);
        clr_n = 1'b1;
        acks = 0;
        for (int t = 0; t < 5; t++) begin
            step();
            if (fire_ack !== 1'b0) acks++;
        end
        checks++; if (acks != 0 || proj_active !== 4'b0000) begin
            failures++; $display("FAIL hold_idle got=%b acks=%0d exp=0000 acks=0", proj_active, acks); end
        checks++; if (player_x !== 10'd320) begin failures++; $display("FAIL hold_player_x got=%0d exp=320", player_x); end
        shoot = 1'b0; right = 1'b0;
    endtask

    initial begin
        test_reset();
        test_move();
        test_fire();
        test_collide();
        test_no_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
